// File: rtl/pandas_pkg.sv
// Shared types for the streaming compare unit: op encoding, FSM states, S1 control payload
// and the one-hot cmd validity check.
package pandas_pkg;

  localparam int NUM_SIZE_DEF      = 32;
  localparam int CMD_SIZE_LOG2_DEF = 3;
  localparam int NUM_OPS           = 6;
  localparam int CMD_MAX_W         = 256;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_e;

  typedef logic [NUM_OPS-1:0] op_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Lane-independent part of the S1 payload; operands and keep are sized by the top.
  typedef struct packed {
    logic last;
    op_t  op;
  } s1_ctl_t;

  // Exactly one of the defined op bits set, and no reserved bit set.
  function automatic logic is_valid_cmd(input logic [CMD_MAX_W-1:0] c);
    return (c[CMD_MAX_W-1:NUM_OPS] == '0) && $onehot(c[NUM_OPS-1:0]);
  endfunction

endpackage

// File: rtl/pandas_cmp_stream_cmp_lane.sv
// One signed compare under a one-hot op; an all-zero op yields 0.
module cmp_lane
  import pandas_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEF
) (
  input  logic signed [NUM_SIZE-1:0] a_i,
  input  logic signed [NUM_SIZE-1:0] b_i,
  input  op_t                        op_i,
  output logic                       res_o
);

  logic eq, lt;

  assign eq = (a_i == b_i);
  assign lt = (a_i < b_i);

  assign res_o = (op_i[CMP_EQ] &  eq)        |
                 (op_i[CMP_NE] & ~eq)        |
                 (op_i[CMP_LT] &  lt)        |
                 (op_i[CMP_LE] & (lt | eq))  |
                 (op_i[CMP_GT] & ~(lt | eq)) |
                 (op_i[CMP_GE] & ~lt);

endmodule

// File: rtl/pandas_cmp_stream.sv
// Multi-lane streaming signed compare with per-column saturating popcount.
// Two register stages (S1 operands, S2 mask/count); the whole pipe freezes on output stall.
module pandas_cmp_stream
  import pandas_pkg::*;
#(
  parameter int NUM_SIZE      = NUM_SIZE_DEF,
  parameter int LANES         = 4,
  parameter int CMD_SIZE_LOG2 = CMD_SIZE_LOG2_DEF,
  parameter int CNT_W         = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [2**CMD_SIZE_LOG2-1:0] cmd_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*NUM_SIZE-1:0]   in1_i,
  input  logic [LANES*NUM_SIZE-1:0]   in2_i,
  input  logic [LANES-1:0]            in_keep_i,
  input  logic                        in_last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANES-1:0]            out_mask_o,
  output logic                        out_last_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        err_o
);

  typedef struct packed {
    logic [LANES-1:0][NUM_SIZE-1:0] a;
    logic [LANES-1:0][NUM_SIZE-1:0] b;
    logic [LANES-1:0]               keep;
    s1_ctl_t                        ctl;
  } s1_t;

  state_e           state_q, state_d;
  op_t              cmd_q, op_in;
  logic             cmd_ok, first_beat, set_err, err_q;
  logic             stall, accept;
  s1_t              s1_d, s1_q;
  logic             vld1_q, vld2_q, last2_q;
  logic [LANES-1:0] res, mask_d, mask_q;
  logic [CNT_W-1:0] acc_q, acc_d, base;
  logic [CNT_W:0]   sum;

  assign stall      = vld2_q && !out_ready_i;
  assign in_ready_o = reset_ni && !stall;
  assign accept     = in_valid_i && in_ready_o;
  assign cmd_ok     = is_valid_cmd(CMD_MAX_W'(cmd_i));

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !in_last_i) state_d = ST_RUN;
      ST_RUN:  if (accept &&  in_last_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. A bad cmd maps to an all-zero op so every lane compares false.
  always_comb begin
    first_beat = (state_q == ST_IDLE);
    op_in      = cmd_q;
    set_err    = 1'b0;
    if (first_beat) begin
      op_in   = cmd_ok ? cmd_i[NUM_OPS-1:0] : '0;
      set_err = accept && !cmd_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept && first_beat) cmd_q <= op_in;
      if (set_err)              err_q <= 1'b1;
    end
  end

  always_comb begin
    s1_d          = '0;
    s1_d.a        = in1_i;
    s1_d.b        = in2_i;
    s1_d.keep     = in_keep_i;
    s1_d.ctl.last = in_last_i;
    s1_d.ctl.op   = op_in;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cmp_lane #(.NUM_SIZE(NUM_SIZE)) u_lane (
      .a_i  (s1_q.a[i]),
      .b_i  (s1_q.b[i]),
      .op_i (s1_q.ctl.op),
      .res_o(res[i])
    );
  end

  assign mask_d = res & s1_q.keep;

  // A column's first beat starts from 0 when the beat it follows in S2 closed a column.
  always_comb begin
    base = (vld2_q && last2_q) ? '0 : acc_q;
    sum  = {1'b0, base};
    for (int i = 0; i < LANES; i++) sum = sum + (CNT_W+1)'(mask_d[i]);
    acc_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      s1_q    <= '0;
      mask_q  <= '0;
      last2_q <= 1'b0;
      acc_q   <= '0;
    end else if (!stall) begin
      vld1_q <= accept;
      vld2_q <= vld1_q;
      if (accept) s1_q <= s1_d;
      if (vld1_q) begin
        mask_q  <= mask_d;
        last2_q <= s1_q.ctl.last;
        acc_q   <= acc_d;
      end else if (vld2_q && last2_q) begin
        acc_q   <= '0;
      end
    end
  end

  assign out_valid_o = vld2_q;
  assign out_mask_o  = mask_q;
  assign out_last_o  = last2_q;
  assign count_o     = acc_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pandas_cmp_stream.sv
// Bench for pandas_cmp_stream: directed vector table plus random traffic against a column-level model.
module tb_pandas_cmp_stream;

  localparam int NS = 32, LN = 4, CL2 = 3, CW = 32;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic [7:0]   cmd = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [127:0] in1 = '0, in2 = '0;
  logic [3:0]   in_keep = '0;
  logic         in_last = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [3:0]   out_mask;
  logic         out_last;
  logic [31:0]  count;
  logic         err;

  always #5 clk = ~clk;

  pandas_cmp_stream #(.NUM_SIZE(NS), .LANES(LN), .CMD_SIZE_LOG2(CL2), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_ni(reset_n), .cmd_i(cmd), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in1_i(in1), .in2_i(in2), .in_keep_i(in_keep), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_mask_o(out_mask),
    .out_last_o(out_last), .count_o(count), .err_o(err)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic        last;
    logic [31:0] cnt;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  logic  in_col_m = 1'b0, err_m = 1'b0;
  logic [5:0] op_m = '0;
  longint acc_m = 0;
  int    cyc = 0, last_lat = 0;

  function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [3:0] ref_mask(input logic [5:0] op, input logic [127:0] a,
                                          input logic [127:0] b, input logic [3:0] k);
    logic [3:0] m;
    int x, y;
    logic r;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      x = a[i*32 +: 32];
      y = b[i*32 +: 32];
      case (op)
        6'b000001: r = (x == y);
        6'b000010: r = (x != y);
        6'b000100: r = (x <  y);
        6'b001000: r = (x <= y);
        6'b010000: r = (x >  y);
        6'b100000: r = (x >= y);
        default:   r = 1'b0;
      endcase
      m[i] = k[i] & r;
    end
    return m;
  endfunction

  // Monitor and column-level model, evaluated mid-cycle on the falling edge.
  initial begin : mon
    logic       prev_stall;
    logic [3:0] prev_mask;
    logic       prev_last;
    logic [31:0] prev_cnt;
    beat_t      e;
    logic       ok;
    prev_stall = 1'b0;
    prev_mask = '0; prev_last = 1'b0; prev_cnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        in_col_m = 1'b0; err_m = 1'b0; acc_m = 0; prev_stall = 1'b0;
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_mask", out_mask, prev_mask);
          chk("stall_last", out_last, prev_last);
          chk("stall_count", count, prev_cnt);
        end
        chk("err", err, err_m);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_mask", out_mask, e.mask);
            chk("sb_last", out_last, e.last);
            if (e.last) chk("sb_count", count, e.cnt);
            last_lat = cyc - e.cyc;
            e.mask = out_mask; e.last = out_last; e.cnt = count;
            got_q.push_back(e);
          end
        end
        if (in_valid && in_ready) begin
          if (!in_col_m) begin
            ok = ($countones(cmd) == 1) && (cmd[7:6] == 2'b00);
            if (!ok) err_m = 1'b1;
            op_m = ok ? cmd[5:0] : 6'b0;
          end
          e.mask = ref_mask(op_m, in1, in2, in_keep);
          acc_m  = acc_m + $countones(e.mask);
          if (acc_m > 64'hFFFF_FFFF) acc_m = 64'hFFFF_FFFF;
          e.last = in_last;
          e.cnt  = acc_m[31:0];
          e.cyc  = cyc;
          exp_q.push_back(e);
          if (in_last) begin acc_m = 0; in_col_m = 1'b0; end
          else in_col_m = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_mask = out_mask; prev_last = out_last; prev_cnt = count;
      end
    end
  end

  task automatic sync(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [7:0] c, input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] k, input logic l);
    int n;
    n = 0;
    cmd = c; in1 = a; in2 = b; in_keep = k; in_last = l; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string nm);
    int t;
    t = 0;
    while (got_q.size() < n && t < 200) begin @(negedge clk); #1; t++; end
    if (got_q.size() < n) chk(nm, got_q.size(), n);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string      nm;
    logic [7:0] cmd;
    logic [3:0] mask;
    int         cnt;
  } vec_t;

  vec_t vt[7];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [127:0] opa, opb, x;
    logic [3:0]   bp_keep[6];
    logic [3:0]   pat;
    beat_t        g;
    logic         any_last, done;
    int           bad;

    vt[0] = '{"EQ",  8'h01, 4'b0110, 2};
    vt[1] = '{"NE",  8'h02, 4'b1001, 2};
    vt[2] = '{"LT",  8'h04, 4'b0001, 1};
    vt[3] = '{"LE",  8'h08, 4'b0111, 3};
    vt[4] = '{"GT",  8'h10, 4'b1000, 1};
    vt[5] = '{"GE",  8'h20, 4'b1110, 3};
    vt[6] = '{"BAD", 8'h06, 4'b0000, 0};
    opa = pack4(-5, 0, 7, 7);
    opb = pack4(3, 0, 7, -8);

    // Reset held with traffic offered
    reset_n = 1'b0; in_valid = 1'b1; cmd = 8'h01; in_keep = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_err", err, 0);
      chk("rst_mask", {out_last, out_mask}, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Ops sweep, single-beat columns
    foreach (vt[i]) begin
      got_q.delete();
      drive(vt[i].cmd, opa, opb, 4'hF, 1'b1);
      wait_got(1, {vt[i].nm, "_timeout"});
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        chk({vt[i].nm, "_mask"}, g.mask, vt[i].mask);
        chk({vt[i].nm, "_count"}, g.cnt, vt[i].cnt);
        chk({vt[i].nm, "_last"}, g.last, 1);
        chk({vt[i].nm, "_latency"}, last_lat, 2);
      end
    end
    chk("bad_err", err, 1);
    got_q.delete();
    drive(8'h01, opa, opa, 4'hF, 1'b1);
    wait_got(1, "after_bad_timeout");
    chk("err_sticky", err, 1);
    if (got_q.size() > 0) chk("after_bad_count", got_q[0].cnt, 4);

    // Multi-beat EQ column; cmd change mid-column ignored
    got_q.delete();
    x = {$urandom, $urandom, $urandom, $urandom};
    drive(8'h01, x, x, 4'hF, 1'b0);
    drive(8'h04, x, x, 4'hF, 1'b0);
    drive(8'h04, x, x, 4'b0011, 1'b1);
    wait_got(3, "multi_timeout");
    if (got_q.size() == 3) begin
      chk("multi_mask0", got_q[0].mask, 4'hF);
      chk("multi_mask2", got_q[2].mask, 4'b0011);
      chk("multi_last", {got_q[0].last, got_q[1].last, got_q[2].last}, 3'b001);
      chk("multi_count", got_q[2].cnt, 10);
    end

    // Backpressure: ready pattern 1,0,0,1 under continuous input
    got_q.delete();
    bp_keep = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h8, 4'h5};
    pat = 4'b1001;
    fork
      for (int i = 0; i < 6; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        drive(8'h01, x, x, bp_keep[i], i == 5);
      end
      for (int t = 0; t < 24; t++) begin
        out_ready = pat[t % 4];
        @(posedge clk); #1;
      end
    join
    out_ready = 1'b1;
    wait_got(6, "bp_timeout");
    chk("bp_n", got_q.size(), 6);
    if (got_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("bp_mask%0d", i), got_q[i].mask, bp_keep[i]);
      chk("bp_count", got_q[5].cnt, 13);
    end

    // Reset in the middle of a 4-beat column
    got_q.delete();
    x = {$urandom, $urandom, $urandom, $urandom};
    drive(8'h01, x, x, 4'hF, 1'b0);
    drive(8'h01, x, x, 4'hF, 1'b0);
    sync(1);
    reset_n = 1'b0;
    sync(2);
    reset_n = 1'b1;
    any_last = 1'b0;
    foreach (got_q[i]) any_last |= got_q[i].last;
    chk("mid_no_last", any_last, 0);
    got_q.delete();
    @(negedge clk);
    chk("mid_err_cleared", err, 0);
    @(posedge clk); #1;
    drive(8'h01, pack4(9, -9, 0, 123), pack4(9, -9, 0, 123), 4'hF, 1'b1);
    wait_got(1, "mid_timeout");
    chk("mid_n", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("mid_last", got_q[0].last, 1);
      chk("mid_count", got_q[0].cnt, 4);
    end

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [127:0] ra, rb;
          logic [7:0]   rc;
          logic [31:0]  v;
          for (int l = 0; l < 4; l++) begin
            v = pick();
            ra[l*32 +: 32] = v;
            rb[l*32 +: 32] = ($urandom_range(0, 2) == 0) ? v : pick();
          end
          rc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'(1 << $urandom_range(0, 5));
          if ($urandom_range(0, 3) == 0) sync($urandom_range(1, 2));
          drive(rc, ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end
        done = 1'b1;
      end
      while (!done) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    join
    out_ready = 1'b1;
    bad = 0;
    while (exp_q.size() > 0 && bad < 200) begin @(posedge clk); #1; bad++; end
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pandas_cmp_stream.md
Name: pandas_cmp_stream

Overview:
- Streaming, multi-lane successor to the single-pair compare unit. Each beat carries LANES pairs of signed operands and yields a LANES-bit result mask.
- Also keeps a per-column popcount of true results, reported on the last beat. This is the count used by the host-side filter/count path.
- Sits between the column DMA reader and the mask writer, with valid/ready handshakes on both sides.

Parameters:
- NUM_SIZE, 32, width of each signed operand.
- LANES, 4, operand pairs per beat; 1..16.
- CMD_SIZE_LOG2, 3, cmd port is 2**CMD_SIZE_LOG2 bits wide, one-hot.
- CNT_W, 32, width of the per-column true-count accumulator.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; clears all state on a clk edge while low.
- cmd  in  2**CMD_SIZE_LOG2  one-hot op select; sampled on the first beat of a column.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in1  in  LANES*NUM_SIZE  left operands; lane i = bits [i*NUM_SIZE +: NUM_SIZE], signed.
- in2  in  LANES*NUM_SIZE  right operands, same packing.
- in_keep  in  LANES  per-lane enable; a 0 lane forces mask bit 0 and is not counted.
- in_last  in  1  final beat of the column.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream can accept.
- out_mask  out  LANES  compare result per lane.
- out_last  out  1  final beat of the column.
- count  out  CNT_W  total true lanes in the column; meaningful only when out_valid && out_last.
- err  out  1  sticky: cmd was not one-hot when sampled.

Behaviour:
- Reset, while reset is low at a clk edge:
  - out_valid=0, out_mask=0, out_last=0, count=0, err=0.
  - Pipeline emptied, FSM to IDLE, accumulator=0, in_ready=0.
  - Reset mid-column drops all in-flight beats; the column is not resumed.
- cmd one-hot encoding: bit0 EQ, bit1 NE, bit2 LT, bit3 LE, bit4 GT, bit5 GE; remaining bits reserved.
  - If the sampled cmd is not exactly one of bits 0..5 set, all masks for that column are 0 and err is set.
  - err clears only on reset.
- FSM with states IDLE and RUN:
  - IDLE: on an accepted beat, latch cmd into cmd_q. If the beat also has in_last, stay IDLE; else go to RUN.
  - RUN: cmd is ignored and cmd_q is used. An accepted beat with in_last returns to IDLE.
  - A single-beat column (first beat also last) is legal.
- Pipeline: two stages.
  - S1 registers operands, keep, last, and the effective cmd.
  - S2 performs the signed compares, registers the mask, and accumulates the popcount.
  - Latency from in handshake to out_valid is 2 cycles with out_ready held high. Throughput is 1 beat/cycle.
- Handshake and stall:
  - Stall = out_valid && !out_ready. The whole pipeline holds while stalled.
  - in_ready = !reset_active && !stall; combinational from out_ready.
  - Beat accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
  - No beat dropped or duplicated under any valid/ready pattern.
  - Outputs stay stable while out_valid && !out_ready.
- Arithmetic:
  - Compares are two's-complement signed at full NUM_SIZE width.
  - Popcount covers only lanes with mask=1.
  - Accumulator = previous + popcount of the beat entering S2.
  - Accumulator saturates at 2**CNT_W-1; no wrap.
  - count on the last beat includes that beat.
  - The accumulator resets to 0 on the cycle after the last beat is consumed. A new column's first beat may enter S2 on that same cycle, so its popcount is added to 0.
- in_keep all-zero beat: legal; mask 0, contributes 0 to the count.

Decomposition:
- Package pandas_pkg holds:
  - NUM_SIZE and CMD_SIZE_LOG2 defaults.
  - An enum of cmd bit indices (CMP_EQ..CMP_GE).
  - The function is_valid_cmd.
  - A struct for the S1 payload {operands, keep, last, cmd}.
- Sub-module cmp_lane: one signed compare of two NUM_SIZE operands under a one-hot cmd, giving a 1-bit result. Instantiated LANES times via generate.

Test Plan:
- Reset: hold reset low 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, count=0, err=0; in_ready=1 on the first cycle after release.
- Ops sweep, LANES=4, single-beat columns:
  - Operands in1={-5,0,7,7}, in2={3,0,7,-8} (lane0 first).
  - EQ -> mask 4'b0110, count=2. LT -> mask 4'b0001, count=1. GE -> mask 4'b1110, count=3.
  - Each result appears exactly 2 cycles after acceptance.
- Multi-beat column, EQ:
  - 3 beats with all lanes equal, keep=4'b1111 on beats 1-2 and 4'b0011 on beat 3.
  - Beat 3 has in_last -> out_last on the third output, count=10.
  - Changing cmd to LT on beat 2 has no effect.
- Backpressure:
  - out_ready toggles 1,0,0,1 with a continuous input of 6 beats -> all 6 masks delivered in order, none duplicated.
  - in_ready low exactly on the stall cycles; outputs stable while stalled.
- Invalid cmd = 8'b0000_0110 on the first beat -> all masks 0, count=0, err=1 and still 1 after the next valid column.
- Reset mid-column: apply reset after beat 2 of 4 -> no out_last ever emitted for that column. The next column, one beat with 4 equal lanes under EQ, reports count=4.
